// File: rtl/frame_scanout_reader.sv
// Frame buffer read side: streams one H_PIXELS x V_LINES frame of RGB555 pixels out as RGB888 on a valid/ready port.
// The falling edge of frame_read_complete tells the buffer to rewind its read address for the next frame.
module frame_scanout_reader #(
   parameter int H_PIXELS   = 160,
   parameter int V_LINES    = 144,
   parameter int FIFO_DEPTH = 4,
   parameter int REWIND_GAP = 4
) (
   input  logic        clk_ppu,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic [14:0] pixel_data_in,
   output logic        read_pixel_data,
   output logic        frame_read_complete,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [23:0] pix_rgb,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        busy
);

   localparam int TOTAL = H_PIXELS * V_LINES;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int X_W   = $clog2(H_PIXELS);
   localparam int Y_W   = $clog2(V_LINES);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 3);
   localparam int GAP_W = $clog2(REWIND_GAP);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DONE
   } state_t;

   state_t             state;
   logic [X_W-1:0]     x_cnt;
   logic [Y_W-1:0]     y_cnt;
   logic [CNT_W-1:0]   strobe_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               start_pending;
   logic               strobe_sof;
   logic               strobe_eol;
   logic               land_valid;
   logic               land_sof;
   logic               land_eol;

   logic [25:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [FC_W-1:0]    fifo_count;

   logic               fifo_push;
   logic               fifo_pop;
   logic [OCC_W-1:0]   occupancy;
   logic               frame_strobes_done;
   logic               can_strobe;
   logic [25:0]        fifo_head;

   function automatic logic [23:0] expand_rgb555(input logic [14:0] p);
      return {p[4:0], p[4:2], p[9:5], p[9:7], p[14:10], p[14:12]};
   endfunction

   // Occupancy counts queued pixels plus reads still in the RAM pipe, so a stalled sink can never overflow the FIFO
   assign fifo_push          = land_valid;
   assign pix_valid          = (fifo_count != '0);
   assign fifo_pop           = pix_valid && pix_ready;
   assign occupancy          = OCC_W'(fifo_count) + OCC_W'(land_valid) + OCC_W'(read_pixel_data);
   assign frame_strobes_done = (strobe_cnt == CNT_W'(TOTAL));
   assign can_strobe         = (state == READ) && !frame_strobes_done &&
                               (occupancy < OCC_W'(FIFO_DEPTH));

   assign fifo_head = fifo_mem[rd_ptr];
   assign pix_rgb   = pix_valid ? fifo_head[23:0] : 24'h000000;
   assign pix_sof   = pix_valid && fifo_head[25];
   assign pix_eol   = pix_valid && fifo_head[24];
   assign busy      = (state != IDLE) || pix_valid;

   // DONE lasts REWIND_GAP-1 cycles; the IDLE cycle that follows completes the low time of frame_read_complete
   always_ff @(posedge clk_ppu) begin
      if (!reset_n) begin
         state               <= IDLE;
         read_pixel_data     <= 1'b0;
         frame_read_complete <= 1'b1;
         x_cnt               <= '0;
         y_cnt               <= '0;
         strobe_cnt          <= '0;
         gap_cnt             <= '0;
         start_pending       <= 1'b0;
         strobe_sof          <= 1'b0;
         strobe_eol          <= 1'b0;
         land_valid          <= 1'b0;
         land_sof            <= 1'b0;
         land_eol            <= 1'b0;
      end else begin
         read_pixel_data <= 1'b0;
         land_valid      <= read_pixel_data;
         land_sof        <= strobe_sof;
         land_eol        <= strobe_eol;
         case (state)
            IDLE: begin
               if (frame_start || start_pending) begin
                  state               <= READ;
                  frame_read_complete <= 1'b1;
                  start_pending       <= 1'b0;
                  x_cnt               <= '0;
                  y_cnt               <= '0;
                  strobe_cnt          <= '0;
               end
            end
            READ: begin
               if (frame_start) begin
                  start_pending <= 1'b1;
               end
               if (can_strobe) begin
                  read_pixel_data <= 1'b1;
                  strobe_sof      <= (x_cnt == '0) && (y_cnt == '0);
                  strobe_eol      <= (x_cnt == X_W'(H_PIXELS - 1));
                  strobe_cnt      <= strobe_cnt + CNT_W'(1);
                  if (x_cnt == X_W'(H_PIXELS - 1)) begin
                     x_cnt <= '0;
                     if (y_cnt != Y_W'(V_LINES - 1)) begin
                        y_cnt <= y_cnt + Y_W'(1);
                     end
                  end else begin
                     x_cnt <= x_cnt + X_W'(1);
                  end
               end else if (frame_strobes_done && !read_pixel_data) begin
                  state               <= DONE;
                  frame_read_complete <= 1'b0;
                  gap_cnt             <= '0;
               end
            end
            DONE: begin
               if (frame_start) begin
                  start_pending <= 1'b1;
               end
               if (gap_cnt == GAP_W'(REWIND_GAP - 2)) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Skid FIFO bookkeeping; push and pop in the same cycle leave the count unchanged even when full
   always_ff @(posedge clk_ppu) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + FC_W'(1);
            2'b01:   fifo_count <= fifo_count - FC_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk_ppu) begin
      if (reset_n && fifo_push) begin
         fifo_mem[wr_ptr] <= {land_sof, land_eol, expand_rgb555(pixel_data_in)};
      end
   end

endmodule

// File: tb/tb_frame_scanout_reader.sv
// Randomised scoreboard bench for frame_scanout_reader, with a behavioural frame buffer model driving pixel_data_in.
// Uses a short frame (160 x 6) so that several frames, stalls and resets fit in a modest run.
module tb_frame_scanout_reader;

   localparam int H     = 160;
   localparam int V     = 6;
   localparam int DEPTH = 4;
   localparam int GAP   = 4;
   localparam int TOTAL = H * V;
   localparam int BUDGET = TOTAL * 6 + 200;

   logic        clk_ppu = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [14:0] pixel_data_in = 15'h0000;
   logic        pix_ready = 1'b0;
   logic        read_pixel_data;
   logic        frame_read_complete;
   logic        pix_valid;
   logic [23:0] pix_rgb;
   logic        pix_sof;
   logic        pix_eol;
   logic        busy;

   frame_scanout_reader #(
      .H_PIXELS  (H),
      .V_LINES   (V),
      .FIFO_DEPTH(DEPTH),
      .REWIND_GAP(GAP)
   ) dut (
      .clk_ppu            (clk_ppu),
      .reset_n            (reset_n),
      .frame_start        (frame_start),
      .pixel_data_in      (pixel_data_in),
      .read_pixel_data    (read_pixel_data),
      .frame_read_complete(frame_read_complete),
      .pix_valid          (pix_valid),
      .pix_ready          (pix_ready),
      .pix_rgb            (pix_rgb),
      .pix_sof            (pix_sof),
      .pix_eol            (pix_eol),
      .busy               (busy)
   );

   always #5 clk_ppu = ~clk_ppu;

   typedef struct {
      logic [23:0] rgb;
      logic        sof;
      logic        eol;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int ram_mode = 0;
   logic [14:0] ram_const = 15'h0000;
   int ram_seed = 0;
   int ready_mode = 1;

   int strobes = 0;
   int pops = 0;
   int max_out = 0;
   int falls = 0;
   int rises = 0;
   int fall_cycle = 0;
   int rise_cycle = 0;
   int strobes_at_fall = 0;

   function automatic logic [14:0] pixOf(input int addr);
      logic [31:0] a;
      logic [31:0] h;
      a = addr;
      h = a * 32'd40503 + ram_seed;
      case (ram_mode)
         0:       return a[14:0];
         1:       return h[14:0] ^ h[29:15];
         default: return ram_const;
      endcase
   endfunction

   // RGB555 to RGB888 by scaling each 5-bit channel: v*8 + v/4
   function automatic logic [23:0] modelRgb(input logic [14:0] p);
      int r;
      int g;
      int b;
      int packed_rgb;
      r = int'(p[4:0]);
      g = int'(p[9:5]);
      b = int'(p[14:10]);
      packed_rgb = ((r * 8 + r / 4) << 16) | ((g * 8 + g / 4) << 8) | (b * 8 + b / 4);
      return packed_rgb[23:0];
   endfunction

   task automatic pushFrame();
      exp_t e;
      for (int i = 0; i < TOTAL; i++) begin
         e.rgb = modelRgb(pixOf(i));
         e.sof = (i == 0);
         e.eol = ((i % H) == H - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic pushFrameLiteral(input logic [23:0] rgb);
      exp_t e;
      for (int i = 0; i < TOTAL; i++) begin
         e.rgb = rgb;
         e.sof = (i == 0);
         e.eol = ((i % H) == H - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk_ppu);
      #1 frame_start = 1'b1;
      @(posedge clk_ppu);
      #1 frame_start = 1'b0;
   endtask

   task automatic waitFalls(input int target, input string name);
      int n;
      n = 0;
      while (falls < target && n < BUDGET) begin
         @(negedge clk_ppu);
         n++;
      end
      checkOutput(name, longint'(falls >= target), 1);
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < BUDGET) begin
         @(negedge clk_ppu);
         n++;
      end
      checkOutput(name, longint'(!busy && exp_q.size() == 0), 1);
   endtask

   initial begin
      forever begin
         @(posedge clk_ppu);
         cycle++;
      end
   end

   initial begin
      forever begin
         @(posedge clk_ppu);
         #1;
         if (ready_mode == 2) begin
            pix_ready = ($urandom_range(0, 1) == 1);
         end else begin
            pix_ready = (ready_mode == 1);
         end
      end
   end

   // Frame buffer model: one-cycle read latency, address advance per strobe, rewind on a delayed falling edge
   initial begin
      int addr;
      logic s;
      logic f;
      logic r;
      logic d1;
      logic d2;
      addr = 0;
      d1 = 1'b1;
      d2 = 1'b1;
      forever begin
         @(negedge clk_ppu);
         s = read_pixel_data;
         f = frame_read_complete;
         r = reset_n;
         @(posedge clk_ppu);
         #1;
         if (!r) begin
            addr = 0;
            d1 = 1'b1;
            d2 = 1'b1;
         end else begin
            if (s) begin
               pixel_data_in = pixOf(addr);
               addr++;
            end
            d2 = d1;
            d1 = f;
            if (d2 && !d1) begin
               addr = 0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted pixel and checks stall stability and outstanding reads
   initial begin
      logic frc_prev;
      logic stalled;
      logic [25:0] held;
      exp_t e;
      frc_prev = 1'b1;
      stalled = 1'b0;
      held = '0;
      forever begin
         @(negedge clk_ppu);
         if (!reset_n) begin
            strobes = 0;
            pops = 0;
            frc_prev = 1'b1;
            stalled = 1'b0;
         end else begin
            if (read_pixel_data) begin
               strobes++;
            end
            if (frc_prev && !frame_read_complete) begin
               falls++;
               fall_cycle = cycle;
               strobes_at_fall = strobes;
            end
            if (!frc_prev && frame_read_complete) begin
               rises++;
               rise_cycle = cycle;
            end
            frc_prev = frame_read_complete;
            if (stalled) begin
               checkOutput("hold_while_stalled", {pix_valid, pix_rgb, pix_sof, pix_eol}, {1'b1, held});
            end
            if (pix_valid && pix_ready) begin
               pops++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_pixel: got 0x%0h, expected no pixel", pix_rgb);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("pixel", {pix_rgb, pix_sof, pix_eol}, {e.rgb, e.sof, e.eol});
               end
            end
            if (strobes - pops > max_out) begin
               max_out = strobes - pops;
            end
            stalled = pix_valid && !pix_ready;
            held = {pix_rgb, pix_sof, pix_eol};
         end
      end
   end

   initial begin
      logic [14:0] cvals [3];
      logic [23:0] lits [3];
      int base;
      int n;
      cvals = '{15'h7FFF, 15'h001F, 15'h0421};
      lits  = '{24'hFFFFFF, 24'hFF0000, 24'h080808};

      $display("[TB] reset values");
      reset_n = 1'b0;
      repeat (3) @(posedge clk_ppu);
      @(negedge clk_ppu);
      checkOutput("reset_strobe", read_pixel_data, 0);
      checkOutput("reset_frc", frame_read_complete, 1);
      checkOutput("reset_valid", pix_valid, 0);
      checkOutput("reset_rgb", pix_rgb, 0);
      checkOutput("reset_sof", pix_sof, 0);
      checkOutput("reset_eol", pix_eol, 0);
      checkOutput("reset_busy", busy, 0);
      @(posedge clk_ppu);
      #1 reset_n = 1'b1;

      $display("[TB] ramp frame with initial stall");
      ram_mode = 0;
      ready_mode = 0;
      repeat (2) @(posedge clk_ppu);
      pushFrame();
      applyStimulus();
      repeat (30) @(negedge clk_ppu);
      checkOutput("stall_strobes", strobes, DEPTH);
      checkOutput("stall_valid", pix_valid, 1);
      ready_mode = 1;
      waitFalls(1, "frame1_done");
      checkOutput("frame1_falls", falls, 1);
      checkOutput("frame1_strobes_at_fall", strobes_at_fall, TOTAL);
      waitDrain("frame1_drain");

      $display("[TB] random backpressure over two frames");
      ram_mode = 1;
      ram_seed = int'($urandom);
      ready_mode = 2;
      pushFrame();
      applyStimulus();
      waitFalls(2, "rand_frame_a_done");
      ram_seed = int'($urandom);
      pushFrame();
      applyStimulus();
      waitFalls(3, "rand_frame_b_done");
      waitDrain("rand_drain");
      checkOutput("max_outstanding_within_depth", longint'(max_out <= DEPTH), 1);
      checkOutput("rand_strobes_total", strobes, 3 * TOTAL);

      $display("[TB] colour expansion corners");
      ready_mode = 1;
      ram_mode = 2;
      for (int k = 0; k < 3; k++) begin
         ram_const = cvals[k];
         pushFrameLiteral(lits[k]);
         applyStimulus();
         waitFalls(4 + k, "const_frame_done");
      end
      waitDrain("const_drain");

      $display("[TB] frame_start during READ and rewind gap");
      ram_mode = 0;
      base = falls;
      pushFrame();
      applyStimulus();
      repeat (100) @(negedge clk_ppu);
      applyStimulus();
      pushFrame();
      repeat (50) @(negedge clk_ppu);
      applyStimulus();
      waitFalls(base + 1, "queued_first_done");
      n = 0;
      while (rises <= 0 || rise_cycle <= fall_cycle) begin
         if (n >= BUDGET) break;
         @(negedge clk_ppu);
         n++;
      end
      checkOutput("rewind_gap_cycles", rise_cycle - fall_cycle, GAP);
      waitFalls(base + 2, "queued_second_done");
      waitDrain("queued_drain");
      repeat (20) @(negedge clk_ppu);
      checkOutput("single_extra_frame_frc", frame_read_complete, 0);
      checkOutput("single_extra_frame_falls", falls, base + 2);

      $display("[TB] reset mid-frame");
      pushFrame();
      applyStimulus();
      base = strobes;
      n = 0;
      while (strobes - base < 500 && n < BUDGET) begin
         @(negedge clk_ppu);
         n++;
      end
      checkOutput("reached_pixel_500", longint'(strobes - base >= 500), 1);
      @(posedge clk_ppu);
      #1 reset_n = 1'b0;
      exp_q.delete();
      @(posedge clk_ppu);
      @(negedge clk_ppu);
      checkOutput("midreset_strobe", read_pixel_data, 0);
      checkOutput("midreset_frc", frame_read_complete, 1);
      checkOutput("midreset_valid", pix_valid, 0);
      checkOutput("midreset_rgb", {pix_rgb, pix_sof, pix_eol}, 0);
      checkOutput("midreset_busy", busy, 0);
      @(posedge clk_ppu);
      #1 reset_n = 1'b1;
      base = falls;
      pushFrame();
      applyStimulus();
      waitFalls(base + 1, "restart_frame_done");
      waitDrain("restart_drain");
      checkOutput("restart_strobes", strobes, TOTAL);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
